// File: rtl/sda_gmem_read_burst_splitter.sv
// sda_gmem_read_burst_splitter
//
// Read-side front end for the shared gmem AXI4 master. One bulk read request
// (base byte address + beat count) is split into AXI4 INCR bursts that never
// cross a 4KB page and never exceed MAX_BURST_LEN beats, with no more than
// MAX_OUTSTANDING bursts in flight. Read data is passed straight through as a
// single stream, and completion is reported with a sticky error flag.
//
// Ports:
//   clk, reset                  kernel clock, asynchronous active-high reset
//   req_valid/req_stop          request handshake (transfer on valid & ~stop)
//   req_addr, req_len           base byte address (beat aligned), beat count
//   data_valid/data_stop        read-data stream handshake
//   data, data_last             read beat, final-beat-of-request marker
//   done_valid/done_stop        completion handshake
//   done_err                    any non-OKAY RRESP seen during the request
//   m_axi_AR*                   AXI4 read-address channel (master side)
//   m_axi_R*                    AXI4 read-data channel (master side)
module sda_gmem_read_burst_splitter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_BURST_LEN   = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_stop,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  data_valid,
  input  logic                  data_stop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_last,
  output logic                  done_valid,
  input  logic                  done_stop,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [7:0]            m_axi_ARLEN,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  output logic [3:0]            m_axi_ARCACHE,
  output logic [2:0]            m_axi_ARPROT,
  output logic [3:0]            m_axi_ARQOS,
  output logic [3:0]            m_axi_ARREGION,
  output logic                  m_axi_ARLOCK,
  output logic                  m_axi_ARID,
  output logic                  m_axi_ARUSER,
  output logic                  m_axi_ARVALID,
  input  logic                  m_axi_ARREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic [1:0]            m_axi_RRESP,
  input  logic                  m_axi_RLAST,
  input  logic                  m_axi_RVALID,
  output logic                  m_axi_RREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr;       // address of the next burst to be loaded
  logic [LEN_WIDTH-1:0]  remaining;  // beats not yet covered by a loaded AR
  logic [LEN_WIDTH-1:0]  total;
  logic [LEN_WIDTH-1:0]  rcvd;
  logic                  err;
  logic [OW-1:0]         outstanding, outstanding_next;
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;

  logic                  r_active, req_fire, ar_fire, r_fire, r_dec, ar_load;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [LEN_WIDTH-1:0]  src_rem;
  logic [8:0]            blen;

  // Beats in the next burst: limited by what is left, the burst cap and the
  // distance to the next 4KB page.
  function automatic logic [8:0] burst_len(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [LEN_WIDTH-1:0]  rem);
    logic [12:0] to_4k;
    logic [8:0]  cap;
    to_4k = (13'd4096 - {1'b0, a[11:0]}) >> SHIFT;
    cap   = (to_4k < 13'(MAX_BURST_LEN)) ? to_4k[8:0] : 9'(MAX_BURST_LEN);
    return (rem < LEN_WIDTH'(cap)) ? rem[8:0] : cap;
  endfunction

  assign r_active = (state == ISSUE) || (state == DRAIN);
  assign req_fire = req_valid && (state == IDLE);
  assign ar_fire  = arvalid && m_axi_ARREADY;
  // Outside a request RREADY stays high so stray beats are swallowed.
  assign m_axi_RREADY = !reset && (r_active ? !data_stop : 1'b1);
  assign r_fire   = r_active && m_axi_RVALID && m_axi_RREADY;
  assign r_dec    = r_fire && m_axi_RLAST && (outstanding != '0);

  always_comb begin
    outstanding_next = outstanding;
    if (ar_fire && !r_dec)      outstanding_next = outstanding + OW'(1);
    else if (!ar_fire && r_dec) outstanding_next = outstanding - OW'(1);
  end

  // The first AR is computed straight from the request so ARVALID can rise
  // the cycle after accept; later ones are loaded as the previous AR fires.
  always_comb begin
    src_addr = (state == IDLE) ? req_addr : addr;
    src_rem  = (state == IDLE) ? req_len  : remaining;
    blen     = burst_len(src_addr, src_rem);
    ar_load  = 1'b0;
    if (state == IDLE)
      ar_load = req_fire && (req_len != '0);
    else if (state == ISSUE)
      ar_load = (!arvalid || ar_fire) && (remaining != '0) && (outstanding_next < MAX_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_fire) state_next = (req_len == '0) ? DONE : ISSUE;
      ISSUE: if (ar_fire && (remaining == '0)) state_next = DRAIN;
      DRAIN: if ((outstanding == '0) && (rcvd == total)) state_next = DONE;
      DONE:  if (!done_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr        <= '0;
      remaining   <= '0;
      total       <= '0;
      rcvd        <= '0;
      err         <= 1'b0;
      outstanding <= '0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      arlen       <= '0;
    end else begin
      if (req_fire) begin
        addr      <= req_addr;
        remaining <= req_len;
        total     <= req_len;
        rcvd      <= '0;
        err       <= 1'b0;
      end
      if (ar_load) begin
        araddr    <= src_addr;
        arlen     <= 8'(blen - 9'd1);
        addr      <= src_addr + (ADDR_WIDTH'(blen) << SHIFT);
        remaining <= src_rem - LEN_WIDTH'(blen);
        arvalid   <= 1'b1;
      end else if (ar_fire) begin
        arvalid   <= 1'b0;
      end
      if (r_fire) begin
        rcvd <= rcvd + LEN_WIDTH'(1);
        if (m_axi_RRESP != 2'b00) err <= 1'b1;
      end
      outstanding <= outstanding_next;
    end
  end

  assign req_stop   = reset || (state != IDLE);
  assign data       = m_axi_RDATA;
  assign data_valid = r_active && m_axi_RVALID;
  assign data_last  = data_valid && (rcvd == total - LEN_WIDTH'(1));
  assign done_valid = (state == DONE);
  assign done_err   = done_valid && err;

  assign m_axi_ARADDR   = araddr;
  assign m_axi_ARLEN    = arlen;
  assign m_axi_ARVALID  = arvalid;
  assign m_axi_ARSIZE   = 3'(SHIFT);
  assign m_axi_ARBURST  = 2'b01;
  assign m_axi_ARCACHE  = 4'b0011;
  assign m_axi_ARPROT   = 3'b000;
  assign m_axi_ARQOS    = 4'b0000;
  assign m_axi_ARREGION = 4'b0000;
  assign m_axi_ARLOCK   = 1'b0;
  assign m_axi_ARID     = 1'b0;
  assign m_axi_ARUSER   = 1'b0;

endmodule

// File: tb/tb_sda_gmem_read_burst_splitter.sv
// Directed bench for sda_gmem_read_burst_splitter. A small AXI slave model
// returns RDATA = beat byte address / 8, so every request's data stream must
// be an incrementing word sequence starting at req_addr/8.
module tb_sda_gmem_read_burst_splitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_stop;
  logic [63:0] req_addr = '0;
  logic [31:0] req_len = '0;
  logic        data_valid;
  logic        data_stop = 1'b0;
  logic [63:0] data;
  logic        data_last;
  logic        done_valid;
  logic        done_stop = 1'b0;
  logic        done_err;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [3:0]  arregion;
  logic        arlock, arid, aruser;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  sda_gmem_read_burst_splitter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_stop(req_stop), .req_addr(req_addr), .req_len(req_len),
    .data_valid(data_valid), .data_stop(data_stop), .data(data), .data_last(data_last),
    .done_valid(done_valid), .done_stop(done_stop), .done_err(done_err),
    .m_axi_ARADDR(araddr), .m_axi_ARLEN(arlen), .m_axi_ARSIZE(arsize),
    .m_axi_ARBURST(arburst), .m_axi_ARCACHE(arcache), .m_axi_ARPROT(arprot),
    .m_axi_ARQOS(arqos), .m_axi_ARREGION(arregion), .m_axi_ARLOCK(arlock),
    .m_axi_ARID(arid), .m_axi_ARUSER(aruser), .m_axi_ARVALID(arvalid),
    .m_axi_ARREADY(arready), .m_axi_RDATA(rdata), .m_axi_RRESP(rresp),
    .m_axi_RLAST(rlast), .m_axi_RVALID(rvalid), .m_axi_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } ar_t;

  ar_t         ar_q[$];
  ar_t         rq[$];
  logic [63:0] beat_d[$];
  logic        beat_l[$];
  logic        done_e[$];

  // Written only by the initial block.
  int r_allow   = 0;
  int ar_mode   = 1;   // 0 never ready, 1 always, 2 only with an RLAST beat, 3 random
  int stop_mode = 0;   // 0 off, 1 toggle every 3 cycles, 2 always stopped
  int err_idx   = -1;

  // Written only by the slave/monitor process.
  int r_beat = 0, bursts_done = 0, beat_total = 0, cyc = 0;
  int inflight = 0, max_inflight = 0, coincide = 0, stab_err = 0, rready_err = 0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_a = '0;
  logic [7:0]  hold_l = '0;

  int errors = 0;
  int checks = 0;

  // AXI slave + monitor: drive on the falling edge, then record the
  // handshakes that the next rising edge will perform.
  always begin
    ar_t item;
    @(negedge clk);
    if (rq.size() > 0 && bursts_done < r_allow) begin
      rvalid = 1'b1;
      rdata  = (rq[0].addr >> 3) + 64'(r_beat);
      rlast  = (r_beat == rq[0].len - 1);
      rresp  = (beat_total == err_idx) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      rdata  = '0;
    end
    case (ar_mode)
      0:       arready = 1'b0;
      1:       arready = 1'b1;
      2:       arready = rvalid & rlast;
      default: arready = 1'($urandom_range(0, 1));
    endcase
    data_stop = (stop_mode == 2) || ((stop_mode == 1) && ((cyc / 3) % 2 == 1));
    #1;
    if (reset) begin
      hold_v = 1'b0;
    end else if (arvalid) begin
      if (hold_v && (araddr !== hold_a || arlen !== hold_l)) stab_err++;
      hold_v = !arready;
      hold_a = araddr;
      hold_l = arlen;
    end else begin
      if (hold_v) stab_err++;
      hold_v = 1'b0;
    end
    if (arvalid && arready) begin
      item.addr = araddr;
      item.len  = int'(arlen) + 1;
      ar_q.push_back(item);
      rq.push_back(item);
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
    end
    if (rvalid && rready) begin
      beat_total++;
      if (rlast) begin
        void'(rq.pop_front());
        r_beat = 0;
        bursts_done++;
        inflight--;
        if (arvalid && arready) coincide++;
      end else begin
        r_beat++;
      end
    end
    if (data_valid && (rready !== !data_stop)) rready_err++;
    if (data_valid && !data_stop) begin
      beat_d.push_back(data);
      beat_l.push_back(data_last);
    end
    if (done_valid && !done_stop) done_e.push_back(done_err);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [63:0] a, input logic [31:0] l);
    int t;
    t = 0;
    @(negedge clk);
    while (req_stop && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_ready", 64'(req_stop), 64'(0));
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int t;
    t = 0;
    while (done_e.size() <= base && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(done_e.size() > base), 64'(1));
  endtask

  task automatic check_stream(input string tag, input int base, input logic [63:0] w0, input int n);
    int bad, lastcnt, lastpos;
    bad = 0;
    lastcnt = 0;
    lastpos = -1;
    for (int i = base; i < beat_d.size(); i++) begin
      if (beat_d[i] !== w0 + 64'(i - base)) bad++;
      if (beat_l[i]) begin
        lastcnt++;
        lastpos = i - base;
      end
    end
    check({tag, "_count"},   64'(beat_d.size() - base), 64'(n));
    check({tag, "_order"},   64'(bad), 64'(0));
    check({tag, "_lastcnt"}, 64'(lastcnt), 64'(1));
    check({tag, "_lastpos"}, 64'(lastpos), 64'(n - 1));
  endtask

  initial begin
    int ab, bb, db, t;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_stop",   64'(req_stop), 64'(1));
    check("rst_arvalid",    64'(arvalid), 64'(0));
    check("rst_rready",     64'(rready), 64'(0));
    check("rst_done_valid", 64'(done_valid), 64'(0));
    check("rst_data_valid", 64'(data_valid), 64'(0));
    check("rst_araddr",     araddr, 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_stop", 64'(req_stop), 64'(0));
    check("idle_rready",   64'(rready), 64'(1));

    // Basic read
    r_allow = 1000;
    ab = ar_q.size(); bb = beat_d.size(); db = done_e.size();
    do_req(64'h1000, 16);
    check("basic_arvalid", 64'(arvalid), 64'(1));
    check("basic_araddr",  araddr, 64'h1000);
    check("basic_arlen",   64'(arlen), 64'(15));
    check("basic_arsize",  64'(arsize), 64'(3));
    check("basic_arburst", 64'(arburst), 64'(1));
    check("basic_arcache", 64'(arcache), 64'(3));
    wait_done(db, "basic_done");
    check("basic_req_stop", 64'(req_stop), 64'(0));
    check("basic_err",   64'(done_e[done_e.size()-1]), 64'(0));
    check("basic_ars",   64'(ar_q.size() - ab), 64'(1));
    check_stream("basic", bb, 64'h200, 16);
    $display("basic read: addr=0x1000 len=16 ars=%0d beats=%0d", ar_q.size() - ab, beat_d.size() - bb);

    // 4KB split
    ab = ar_q.size(); bb = beat_d.size(); db = done_e.size();
    do_req(64'h0FC0, 100);
    wait_done(db, "split_done");
    repeat (5) @(negedge clk);
    check("split_ars",    64'(ar_q.size() - ab), 64'(3));
    check("split_a0",     ar_q[ab].addr, 64'h0FC0);
    check("split_l0",     64'(ar_q[ab].len), 64'(8));
    check("split_a1",     ar_q[ab+1].addr, 64'h1000);
    check("split_l1",     64'(ar_q[ab+1].len), 64'(64));
    check("split_a2",     ar_q[ab+2].addr, 64'h1200);
    check("split_l2",     64'(ar_q[ab+2].len), 64'(28));
    check("split_dones",  64'(done_e.size() - db), 64'(1));
    check_stream("split", bb, 64'h1F8, 100);
    $display("4KB split: addr=0xFC0 len=100 ars=%0d beats=%0d", ar_q.size() - ab, beat_d.size() - bb);

    // len = 0
    ab = ar_q.size(); db = done_e.size();
    do_req(64'h2000, 0);
    #1;
    check("zero_done_valid", 64'(done_valid), 64'(1));
    check("zero_arvalid",    64'(arvalid), 64'(0));
    wait_done(db, "zero_done");
    check("zero_ars", 64'(ar_q.size() - ab), 64'(0));
    check("zero_err", 64'(done_e[done_e.size()-1]), 64'(0));
    $display("len=0: done_valid one cycle after accept, ars=%0d", ar_q.size() - ab);

    // Outstanding limit
    ab = ar_q.size(); bb = beat_d.size(); db = done_e.size();
    r_allow = bursts_done;
    do_req(64'h0, 512);
    repeat (20) @(negedge clk);
    check("out_ars4",    64'(ar_q.size() - ab), 64'(4));
    check("out_arvalid", 64'(arvalid), 64'(0));
    r_allow = bursts_done + 1;
    t = 0;
    while (ar_q.size() - ab < 5 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("out_ars5",  64'(ar_q.size() - ab), 64'(5));
    check("out_addr5", ar_q[ab+4].addr, 64'h800);
    ar_mode = 2;
    r_allow = bursts_done + 100;
    wait_done(db, "out_done");
    check("out_ars_total", 64'(ar_q.size() - ab), 64'(8));
    check("out_coincide",  64'(coincide > 0), 64'(1));
    check("out_max_inflight", 64'(max_inflight), 64'(4));
    check("out_err", 64'(done_e[done_e.size()-1]), 64'(0));
    check_stream("out", bb, 64'h0, 512);
    ar_mode = 1;
    $display("outstanding: len=512 ars=%0d coincident=%0d max_inflight=%0d", ar_q.size() - ab, coincide, max_inflight);

    // Backpressure: random ARREADY, data_stop toggling
    ab = ar_q.size(); bb = beat_d.size(); db = done_e.size();
    ar_mode = 3;
    stop_mode = 1;
    do_req(64'h3F00, 200);
    wait_done(db, "bp_done");
    stop_mode = 0;
    ar_mode = 1;
    check("bp_ars",   64'(ar_q.size() - ab), 64'(4));
    check("bp_a0",    ar_q[ab].addr, 64'h3F00);
    check("bp_l0",    64'(ar_q[ab].len), 64'(32));
    check("bp_l3",    64'(ar_q[ab+3].len), 64'(40));
    check("bp_stable", 64'(stab_err), 64'(0));
    check("bp_rready", 64'(rready_err), 64'(0));
    check_stream("bp", bb, 64'h7E0, 200);
    $display("backpressure: addr=0x3F00 len=200 ars=%0d beats=%0d", ar_q.size() - ab, beat_d.size() - bb);

    // Error path with done backpressure
    bb = beat_d.size(); db = done_e.size();
    err_idx = beat_total + 4;
    done_stop = 1'b1;
    do_req(64'h5000, 16);
    t = 0;
    while (!done_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("err_done_hold", 64'(done_valid), 64'(1));
    check("err_done_err",  64'(done_err), 64'(1));
    done_stop = 1'b0;
    wait_done(db, "err_done");
    check("err_flag", 64'(done_e[done_e.size()-1]), 64'(1));
    check_stream("err", bb, 64'hA00, 16);
    err_idx = -1;
    db = done_e.size();
    do_req(64'h5000, 16);
    wait_done(db, "clean_done");
    check("clean_flag", 64'(done_e[done_e.size()-1]), 64'(0));
    $display("error path: err request flag=1, following request flag=%0d", done_e[done_e.size()-1]);

    // Reset mid-DRAIN, then stray beats absorbed
    bb = beat_d.size();
    stop_mode = 2;
    do_req(64'h2000, 16);
    repeat (4) @(negedge clk);
    check("drain_data_valid", 64'(data_valid), 64'(1));
    reset = 1'b1;
    #1;
    check("mid_req_stop",   64'(req_stop), 64'(1));
    check("mid_arvalid",    64'(arvalid), 64'(0));
    check("mid_rready",     64'(rready), 64'(0));
    check("mid_data_valid", 64'(data_valid), 64'(0));
    check("mid_data_last",  64'(data_last), 64'(0));
    check("mid_done_valid", 64'(done_valid), 64'(0));
    check("mid_arlen",      64'(arlen), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stop_mode = 0;
    t = 0;
    while (rq.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stray_absorbed", 64'(rq.size()), 64'(0));
    check("stray_no_data",  64'(beat_d.size() - bb), 64'(0));
    check("stray_req_stop", 64'(req_stop), 64'(0));
    $display("reset mid-drain: stray beats absorbed, delivered=%0d", beat_d.size() - bb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sda_gmem_read_burst_splitter.md
Name: sda_gmem_read_burst_splitter

Overview:
- Read-side front end for the shared global-memory AXI master of an SDAccel gmem kernel.
- Sits between the action logic and the kernel wrapper's m_axi_gmem read channels (AR/R).
- Accepts one bulk read request (base address, beat count) and splits it into legal AXI4 INCR bursts. No burst crosses a 4KB boundary or exceeds MAX_BURST_LEN. At most MAX_OUTSTANDING bursts are in flight.
- Returns read data as a single stream and reports completion with a sticky error flag.

Parameters:
- ADDR_WIDTH, 64, gmem byte-address width.
- DATA_WIDTH, 64, gmem data width in bits (power of 2, 32..512).
- LEN_WIDTH, 32, request beat-count width.
- MAX_BURST_LEN, 64, maximum beats per AXI burst (1..256).
- MAX_OUTSTANDING, 4, maximum AR bursts issued but not yet completed by RLAST (1..16).

Ports:
- clk  in  1  kernel clock (ap_clk domain).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_stop  out  1  request backpressure; high = not accepted.
- req_addr  in  ADDR_WIDTH  base byte address, aligned to DATA_WIDTH/8.
- req_len  in  LEN_WIDTH  total beats; 0 is legal.
- data_valid  out  1  read beat valid.
- data_stop  in  1  consumer backpressure.
- data  out  DATA_WIDTH  read beat.
- data_last  out  1  final beat of the request.
- done_valid  out  1  request complete.
- done_stop  in  1  completion backpressure.
- done_err  out  1  any non-OKAY RRESP during the request.
- m_axi_ARADDR  out  ADDR_WIDTH  burst address.
- m_axi_ARLEN  out  8  burst length minus 1.
- m_axi_ARSIZE  out  3  log2(DATA_WIDTH/8), constant.
- m_axi_ARBURST  out  2  constant 2'b01 (INCR).
- m_axi_ARCACHE  out  4  constant 4'b0011.
- m_axi_ARPROT / ARQOS / ARREGION / ARLOCK / ARID / ARUSER  out  3/4/4/1/1/1  all constant 0.
- m_axi_ARVALID  out  1  address valid.
- m_axi_ARREADY  in  1  address ready.
- m_axi_RDATA  in  DATA_WIDTH  read data.
- m_axi_RRESP  in  2  read response.
- m_axi_RLAST  in  1  last beat of a burst.
- m_axi_RVALID  in  1  read data valid.
- m_axi_RREADY  out  1  read data ready.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on port reset. All state clears immediately on assertion.
- Reset values: req_stop=1, m_axi_ARVALID=0, done_valid=0, done_err=0, data_valid=0, data_last=0, m_axi_RREADY=0, outstanding=0, state=IDLE. Registered AR fields reset to 0.
- Handshakes:
  - SELF channels: transfer occurs on valid & ~stop.
  - AXI channels: transfer occurs on VALID & READY.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - req_stop=0 (in IDLE only, otherwise 1).
  - On request accept: latch addr, remaining=req_len, rcvd=0, err=0.
  - If req_len==0, go to DONE (no AR issued). Otherwise go to ISSUE.
- ISSUE:
  - blen = min(remaining, MAX_BURST_LEN, beats_to_4k).
  - beats_to_4k = (4096 - addr[11:0]) >> log2(DATA_WIDTH/8).
  - ARADDR/ARLEN are registered. ARVALID is first asserted the cycle after request accept, or the cycle after the previous AR handshake.
  - ARVALID asserts only when outstanding < MAX_OUTSTANDING.
  - Once ARVALID is asserted, ARVALID/ARADDR/ARLEN stay stable until ARREADY.
  - On AR handshake: addr += blen*bytes, remaining -= blen. When remaining reaches 0, go to DRAIN.
- Outstanding counter:
  - +1 on AR handshake; −1 on R handshake with RLAST.
  - Both in the same cycle: counter unchanged.
  - Never exceeds MAX_OUTSTANDING, never underflows.
- R path (ISSUE/DRAIN), combinational pass-through:
  - data = RDATA, data_valid = RVALID, RREADY = ~data_stop.
  - data_last = RVALID & (rcvd == req_len−1).
  - rcvd increments on each R handshake.
  - RRESP != 2'b00 on any accepted beat sets err (sticky). The beat is still delivered.
- DRAIN: when outstanding==0 and rcvd==req_len, go to DONE.
- DONE:
  - done_valid=1, done_err=err.
  - On done_valid & ~done_stop, go to IDLE.
- Stray beats: in IDLE and DONE, RREADY=1 and data_valid=0. Any stray R beats (e.g. left over after a kernel reset mid-burst) are discarded.
- Arithmetic widths:
  - addr arithmetic is ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH.
  - remaining/rcvd are LEN_WIDTH.
  - blen needs 9 bits internally.

Test Plan:
- Basic read: req addr=0x1000, len=16, ARREADY/RVALID always high, data_stop=0 -> one AR with ARADDR=0x1000, ARLEN=15, ARSIZE=3, ARBURST=1; 16 beats; data_last on beat 16 only; done_valid with done_err=0; req_stop returns to 0 after done is accepted.
- 4KB split: addr=0x0FC0, len=100 -> AR sequence (0x0FC0, ARLEN 7), (0x1000, 63), (0x1200, 27); 100 beats; single done.
- Outstanding limit: addr=0, len=512, RVALID held 0 -> exactly 4 ARs; ARVALID then stays low. After one RLAST is accepted, a 5th AR issues. A cycle with both AR handshake and RLAST leaves the count unchanged.
- Backpressure: ARREADY random; data_stop toggled every 3 cycles -> ARADDR/ARLEN stable while ARVALID & ~ARREADY; RREADY == ~data_stop; no beat lost or duplicated (incrementing-pattern check).
- Error path: RRESP=2'b10 on beat 5 of len=16 -> all 16 beats delivered; done_err=1. The next request with clean responses reports done_err=0.
- Corner cases:
  - len=0 -> no ARVALID; done_valid asserted the cycle after accept.
  - reset asserted mid-DRAIN -> all outputs return to reset values in the same cycle; after release, stray RVALID beats are absorbed with data_valid=0.
